// File: rtl/systolic_x_feeder_pkg.sv
// Shared definitions for the systolic X-lane feeder: FSM state encoding,
// default geometry and the lane slice helper.
package systolic_x_feeder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

  localparam int DEF_M          = 5;
  localparam int DEF_N          = 3;
  localparam int DEF_K          = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // Low bit of lane/element 'lane' inside a packed row of 'width'-bit elements.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_x_feeder_x_row_buffer.sv
// M-row by N-lane register file: one full-row write port, and one read port per
// lane with its own row index so the diagonal skew can be read out directly.
module systolic_x_feeder_x_row_buffer
  import systolic_x_feeder_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [DATA_WIDTH*N-1:0] wr_row_i,
  input  logic [N*AW-1:0]         rd_idx_i,
  output logic [DATA_WIDTH*N-1:0] rd_lanes_o
);

  logic [DATA_WIDTH*N-1:0] mem_q [M];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_row_i;
    end
  end

  always_comb begin
    rd_lanes_o = '0;
    for (int i = 0; i < N; i++) begin
      rd_lanes_o[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
        mem_q[rd_idx_i[i*AW +: AW]][lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/systolic_x_feeder.sv
// Buffers one MxN matrix row by row, then replays it onto N X lanes with lane i
// delayed i cycles, zero-flushes the array and pulses frame_done.
module systolic_x_feeder
  import systolic_x_feeder_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FLUSH_CYC  = N + K - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH*N-1:0] in_row,
  output logic [DATA_WIDTH*N-1:0] x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int AW   = (M > 1) ? $clog2(M) : 1;
  localparam int RCW  = $clog2(M + 1);
  localparam int SLEN = M + N - 1;
  localparam int TMAX = (SLEN > FLUSH_CYC) ? SLEN : FLUSH_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  feeder_state_e           state_q;
  logic [RCW-1:0]          row_cnt_q;
  logic [TW-1:0]           t_q;
  logic [DATA_WIDTH*N-1:0] x_out_q;
  logic                    x_valid_q;
  logic                    frame_done_q;

  logic                    wr_en;
  logic [N*AW-1:0]         rd_idx;
  logic [N-1:0]            lane_en;
  logic [DATA_WIDTH*N-1:0] buf_lanes;
  logic [DATA_WIDTH*N-1:0] x_lanes_d;

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_LOAD);
  assign wr_en      = in_valid && in_ready;
  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign frame_done = frame_done_q;

  systolic_x_feeder_x_row_buffer #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_row_buffer (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_addr_i  (row_cnt_q[AW-1:0]),
    .wr_row_i   (in_row),
    .rd_idx_i   (rd_idx),
    .rd_lanes_o (buf_lanes)
  );

  // Lane i reads row t-i; outside 0..M-1 it is a skew-padding zero.
  always_comb begin
    rd_idx  = '0;
    lane_en = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(t_q) >= i) && (int'(t_q) - i < M)) begin
        lane_en[i]          = 1'b1;
        rd_idx[i*AW +: AW]  = AW'(int'(t_q) - i);
      end
    end
  end

  always_comb begin
    x_lanes_d = '0;
    for (int i = 0; i < N; i++) begin
      if (lane_en[i]) begin
        x_lanes_d[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] =
          buf_lanes[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      row_cnt_q    <= '0;
      t_q          <= '0;
      x_out_q      <= '0;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          x_out_q   <= '0;
          x_valid_q <= 1'b0;
          if (in_valid) begin
            if (row_cnt_q == RCW'(M - 1)) begin
              row_cnt_q <= '0;
              t_q       <= '0;
              state_q   <= ST_STREAM;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          x_out_q   <= x_lanes_d;
          x_valid_q <= 1'b1;
          if (t_q == TW'(SLEN - 1)) begin
            t_q     <= '0;
            state_q <= ST_FLUSH;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          x_out_q   <= '0;
          x_valid_q <= 1'b0;
          if (t_q == TW'(FLUSH_CYC - 1)) begin
            t_q     <= '0;
            state_q <= ST_DONE;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          row_cnt_q    <= '0;
          state_q      <= ST_LOAD;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_x_feeder.sv
// Self-checking bench for systolic_x_feeder: skew table, flush/done timing,
// bubbles, ignored input while busy, async reset mid-stream, back-to-back and random frames.
module tb_systolic_x_feeder;

  localparam int M  = 5;
  localparam int N  = 3;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int FL = N + K - 1;
  localparam int SL = M + N - 1;

  typedef logic [DW*N-1:0] row_t;
  typedef struct {
    int   t;
    row_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  row_t in_row = '0;
  logic in_ready;
  row_t x_out;
  logic x_valid;
  logic busy;
  logic frame_done;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cyc[$];
  row_t frame_rows[M];
  row_t obs[SL];
  vec_t tbl[SL];

  systolic_x_feeder #(
    .M          (M),
    .N          (N),
    .K          (K),
    .DATA_WIDTH (DW),
    .FLUSH_CYC  (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) done_cyc.push_back(cyc);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input int l2, input int l1, input int l0);
    return {DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  // Reference: lane i at stream step t carries element i of row t-i, or zero.
  function automatic row_t model_lanes(input int t);
    row_t r = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < M) r[i*DW +: DW] = frame_rows[t-i][i*DW +: DW];
    end
    return r;
  endfunction

  task automatic set_rows(input int base);
    for (int m = 0; m < M; m++) frame_rows[m] = mk(3*m + base + 2, 3*m + base + 1, 3*m + base);
  endtask

  task automatic do_frame(input int gap_mode, input bit junk);
    int  idx = 0;
    int  guard = 0;
    bit  first = 1'b1;
    while (idx < M && guard < 200) begin
      if (!first) chk("frame_done_low_load", frame_done, 0);
      chk("in_ready_load", in_ready, 1);
      chk("x_valid_load", x_valid, 0);
      first = 1'b0;
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_row = in_valid ? frame_rows[idx] : row_t'($urandom);
      step();
      guard++;
      if (in_valid) idx++;
    end
    if (idx < M) begin
      chk("load_timeout", idx, M);
      in_valid = 1'b0;
      return;
    end
    in_valid = junk;
    in_row   = junk ? '1 : '0;
    chk("in_ready_after_load", in_ready, 0);
    chk("x_valid_latency", x_valid, 0);
    for (int t = 0; t < SL; t++) begin
      step();
      chk("x_valid_stream", x_valid, 1);
      chk("x_out_stream", x_out, model_lanes(t));
      chk("in_ready_stream", in_ready, 0);
      chk("busy_stream", busy, 1);
      obs[t] = x_out;
    end
    for (int f = 0; f < FL; f++) begin
      step();
      chk("x_valid_flush", x_valid, 0);
      chk("x_out_flush", x_out, 0);
      chk("in_ready_flush", in_ready, 0);
      chk("frame_done_early", frame_done, 0);
      chk("busy_flush", busy, 1);
    end
    step();
    chk("frame_done_pulse", frame_done, 1);
    chk("in_ready_rearm", in_ready, 1);
    chk("busy_idle", busy, 0);
    in_valid = 1'b0;
  endtask

  task automatic check_table(input string nm);
    for (int k = 0; k < SL; k++) chk(nm, obs[tbl[k].t], tbl[k].exp);
  endtask

  initial begin
    int nd;
    int d1;
    tbl[0] = '{0, mk(0, 0, 1)};
    tbl[1] = '{1, mk(0, 2, 4)};
    tbl[2] = '{2, mk(3, 5, 7)};
    tbl[3] = '{3, mk(6, 8, 10)};
    tbl[4] = '{4, mk(9, 11, 13)};
    tbl[5] = '{5, mk(12, 14, 0)};
    tbl[6] = '{6, mk(15, 0, 0)};

    // reset state
    #12;
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b1;
    step();

    // basic skew + flush/done
    set_rows(1);
    do_frame(0, 1'b0);
    check_table("skew_table");

    // bubbles 1,0,0,1,...
    do_frame(1, 1'b0);
    check_table("bubble_table");

    // input held valid with all-ones while busy, then a fresh frame
    do_frame(0, 1'b1);
    check_table("junk_table");
    for (int m = 0; m < M; m++) frame_rows[m] = row_t'($urandom);
    do_frame(2, 1'b0);

    // async reset on the 3rd x_valid cycle
    set_rows(1);
    for (int m = 0; m < M; m++) begin
      in_valid = 1'b1;
      in_row   = frame_rows[m];
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_reset_x_valid", x_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_x_out", x_out, 0);
    chk("async_rst_x_valid", x_valid, 0);
    chk("async_rst_busy", busy, 0);
    step();
    step();
    rst = 1'b1;
    nd = done_cyc.size();
    chk("rst_release_in_ready", in_ready, 1);
    for (int c = 0; c < 20; c++) step();
    chk("no_done_after_reset", done_cyc.size(), nd);
    do_frame(0, 1'b0);
    check_table("post_reset_table");

    // back-to-back frames
    set_rows(1);
    do_frame(0, 1'b0);
    d1 = done_cyc[$];
    set_rows(16);
    do_frame(0, 1'b0);
    chk("b2b_first_lanes", obs[0], mk(0, 0, 16));
    chk("b2b_done_gap_ge19", ((done_cyc[$] - d1) >= 19), 1);

    // random frames, random bubbles, random junk
    for (int r = 0; r < 6; r++) begin
      for (int m = 0; m < M; m++) frame_rows[m] = row_t'($urandom);
      do_frame(2, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
